// File: rtl/pp_acc_pkg.sv
// Shared definitions for the iterative partial-product row accumulator.
// Holds the FSM state encodings, the group-count helper and the
// index-width helper used by pp_row_accumulator and pp_row_group.
package pp_acc_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_CALC = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // Number of compute groups: ceil(w / r).
  function automatic int unsigned n_groups(input int unsigned w, input int unsigned r);
    return (w + r - 1) / r;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned bits;
    bits = 1;
    while ((64'd1 << bits) < 64'(n)) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/pp_row_group.sv
// Combinational slice of the AND partial-product matrix.
// Sums R consecutive rows starting at row 'base'; row i is
// (a AND {W{b[i]}}) << i in 2W bits. Rows at or beyond W are masked.
// When sgn is set, a is sign-extended and the MSB row is subtracted,
// giving the two's-complement product modulo 2^(2W).
// Ports: a, b (operands), base (first row index), sgn (signed mode),
//        sum_c (2W-bit sum of the selected rows).
module pp_row_group
  import pp_acc_pkg::*;
#(
  parameter int unsigned W = 43,
  parameter int unsigned R = 4,
  localparam int unsigned BW = clog2(W + R)
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [BW-1:0]  base,
  input  logic           sgn,
  output logic [2*W-1:0] sum_c
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] row;
  logic [BW-1:0]  row_idx;
  logic [W-1:0]   b_shift;

  // Accumulate the masked, shifted rows of this group.
  always_comb begin
    a_ext   = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sum_c   = '0;
    row     = '0;
    row_idx = '0;
    b_shift = '0;
    for (int unsigned k = 0; k < R; k++) begin
      row_idx = base + BW'(k);
      b_shift = b >> row_idx;
      row     = b_shift[0] ? (a_ext << row_idx) : '0;
      if (row_idx < BW'(W)) begin
        // The MSB multiplier bit carries negative weight in signed mode.
        if (sgn && (row_idx == BW'(W - 1))) sum_c = sum_c - row;
        else                                sum_c = sum_c + row;
      end
    end
  end

endmodule

// File: rtl/pp_row_accumulator.sv
// Iterative W x W multiplier: accumulates ROWS_PER_CYCLE partial-product
// rows per clock into a 2W-bit product, with valid/ready on both sides.
// Optional macro PP_ACC_SIGNED_EN adds is_signed for two's-complement mode.
// Ports: clk, rst (async, active-high); in_valid/in_ready, a, b
//        [, is_signed]; out_valid/out_ready, p (2W-bit product);
//        busy (high while computing).
module pp_row_accumulator
  import pp_acc_pkg::*;
#(
  parameter int unsigned W              = 43,
  parameter int unsigned ROWS_PER_CYCLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef PP_ACC_SIGNED_EN
  input  logic           is_signed,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned NG = n_groups(W, ROWS_PER_CYCLE);
  localparam int unsigned GW = clog2(NG);
  localparam int unsigned BW = clog2(W + ROWS_PER_CYCLE);

  logic [ST_W-1:0] state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            sgn_in;
  logic [BW-1:0]   base;
  logic [2*W-1:0]  grp_sum;

`ifdef PP_ACC_SIGNED_EN
  assign sgn_in = is_signed;
`else
  assign sgn_in = 1'b0;
`endif

  assign base = BW'(grp_q) * BW'(ROWS_PER_CYCLE);

  pp_row_group #(
    .W (W),
    .R (ROWS_PER_CYCLE)
  ) u_group (
    .a     (a_q),
    .b     (b_q),
    .base  (base),
    .sgn   (sgn_q),
    .sum_c (grp_sum)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = sgn_in;
          grp_d   = '0;
          acc_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_q + grp_sum;
        if (grp_q == GW'(NG - 1)) begin
          grp_d   = '0;
          state_d = ST_DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered images of the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_CALC);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      grp_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      grp_q       <= grp_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = acc_q;

endmodule
